// File: rtl/pool_pkg.sv
// Shared types for the 2x2/stride-2 pooling window path.
// Holds the sample/channel defaults, the window-former state enum and the window slot offset helper.
package pool_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int CH_DEF     = 64;

  typedef enum logic [1:0] {IDLE, TOP, BOTTOM, TAIL} state_t;

  // Bit offset of channel c, window row r (0=top), col k (0=left).
  function automatic int win_off(input int c, input int r, input int k, input int dw);
    return (c * 4 + r * 2 + k) * dw;
  endfunction
endpackage

// File: rtl/pool_line_buf.sv
// Top-row store for window pairs: half-entry writes land on the clock edge.
// Reads are combinational. The buffer has no flow control.
module pool_line_buf #(
  parameter int W     = 64,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic            clk,
  input  logic [AW-1:0]   wr_addr,
  input  logic            wr_lo,
  input  logic            wr_hi,
  input  logic [W-1:0]    din,
  input  logic [AW-1:0]   rd_addr,
  output logic [2*W-1:0]  rd_dat
);
  logic [2*W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_lo) mem[wr_addr][W-1:0]   <= din;
    if (wr_hi) mem[wr_addr][2*W-1:W] <= din;
  end

  assign rd_dat = mem[rd_addr];
endmodule

// File: rtl/pool_window_former.sv
// Raster-order pixel stream in, one 2x2 window per channel out 1 cycle after the bottom-right pixel.
// The block accepts one pixel per cycle and has no backpressure; the downstream block always accepts.
module pool_window_former
  import pool_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CH     = CH_DEF,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sof,
  input  logic                   valid_in,
  input  logic [CH*DATA_W-1:0]   pix_in,
  output logic                   win_valid,
  output logic [CH*4*DATA_W-1:0] win_out,
  output logic                   frame_done,
  output logic                   frame_err
);
  localparam int PW   = CH * DATA_W;
  localparam int NENT = IMG_W / 2;
  localparam int AW   = (NENT > 1) ? $clog2(NENT) : 1;
  localparam int CW   = $clog2(IMG_W);
  localparam int RW   = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_PEN  = RW'(IMG_H - 2);
  localparam bit ODD_W = (IMG_W % 2) == 1;
  localparam bit ODD_H = (IMG_H % 2) == 1;

  state_t          state_q, state_d, estate;
  logic [CW-1:0]   col_q, col_d, ecol;
  logic [RW-1:0]   row_q, row_d, erow;
  logic [PW-1:0]   hold_q, hold_d;
  logic [4*PW-1:0] win_d, win_asm;
  logic            wv_d, done_d, err_d;
  logic            start, accept, wr_lo, wr_hi;
  logic [AW-1:0]   addr;
  logic [2*PW-1:0] top_dat;

  pool_line_buf #(.W(PW), .DEPTH(NENT), .AW(AW)) u_line_buf (
    .clk     (clk),
    .wr_addr (addr),
    .wr_lo   (wr_lo),
    .wr_hi   (wr_hi),
    .din     (pix_in),
    .rd_addr (addr),
    .rd_dat  (top_dat)
  );

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    hold_d  = hold_q;
    win_d   = win_out;
    wv_d    = 1'b0;
    done_d  = 1'b0;
    wr_lo   = 1'b0;
    wr_hi   = 1'b0;
    win_asm = '0;

    // A qualified sof anywhere restarts at (0,0) in TOP, so stale rows are never paired.
    start  = valid_in & sof;
    accept = valid_in & (sof | (state_q != IDLE));
    err_d  = valid_in & (sof ? (state_q != IDLE) : (state_q == IDLE));
    estate = start ? TOP : state_q;
    ecol   = start ? '0 : col_q;
    erow   = start ? '0 : row_q;
    addr   = AW'(ecol >> 1);

    for (int c = 0; c < CH; c++) begin
      win_asm[win_off(c, 0, 0, DATA_W) +: DATA_W] = top_dat[c*DATA_W +: DATA_W];
      win_asm[win_off(c, 0, 1, DATA_W) +: DATA_W] = top_dat[PW + c*DATA_W +: DATA_W];
      win_asm[win_off(c, 1, 0, DATA_W) +: DATA_W] = hold_q[c*DATA_W +: DATA_W];
      win_asm[win_off(c, 1, 1, DATA_W) +: DATA_W] = pix_in[c*DATA_W +: DATA_W];
    end

    if (accept) begin
      case (estate)
        TOP: begin
          wr_lo = !ecol[0] && !(ODD_W && ecol == COL_LAST);
          wr_hi = ecol[0];
        end
        BOTTOM: begin
          if (!ecol[0]) hold_d = pix_in;
          else begin
            wv_d  = 1'b1;
            win_d = win_asm;
          end
        end
        default: ;
      endcase

      if (ecol == COL_LAST) begin
        col_d = '0;
        if (erow == ROW_LAST) begin
          row_d   = '0;
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          row_d = erow + RW'(1);
          if (estate == TOP)               state_d = BOTTOM;
          else if (ODD_H && erow == ROW_PEN) state_d = TAIL;
          else                             state_d = TOP;
        end
      end else begin
        col_d   = ecol + CW'(1);
        row_d   = erow;
        state_d = estate;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      hold_q     <= '0;
      win_out    <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      hold_q     <= hold_d;
      win_out    <= win_d;
      win_valid  <= wv_d;
      frame_done <= done_d;
      frame_err  <= err_d;
    end
  end
endmodule

// File: tb/tb_pool_window_former.sv
// Directed bench for pool_window_former: a 4x4 instance and a 5x5 instance on shared inputs.
module tb_pool_window_former;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sof = 1'b0;
  logic         valid_in = 1'b0;
  logic [31:0]  pix_in = '0;
  logic         wv4, fd4, fe4, wv5, fd5, fe5;
  logic [127:0] wo4, wo5;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pool_window_former #(.DATA_W(16), .CH(2), .IMG_W(4), .IMG_H(4)) u4 (
    .clk(clk), .rst(rst), .sof(sof), .valid_in(valid_in), .pix_in(pix_in),
    .win_valid(wv4), .win_out(wo4), .frame_done(fd4), .frame_err(fe4));

  pool_window_former #(.DATA_W(16), .CH(2), .IMG_W(5), .IMG_H(5)) u5 (
    .clk(clk), .rst(rst), .sof(sof), .valid_in(valid_in), .pix_in(pix_in),
    .win_valid(wv5), .win_out(wo5), .frame_done(fd5), .frame_err(fe5));

  typedef struct {
    int r; int c; bit s; bit vld; bit done;
    logic [15:0] tl0; logic [15:0] br1;
  } vec_t;
  vec_t tbl[16];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pixv(input int r, input int c, input int tag);
    logic [15:0] a, b;
    a = 16'(r * 16 + c + tag);
    b = 16'(256 + r * 16 + c + tag);
    return {b, a};
  endfunction

  function automatic logic [127:0] exp_win(input int wr, input int wc);
    logic [127:0] w;
    w = '0;
    for (int ch = 0; ch < 2; ch++)
      for (int r = 0; r < 2; r++)
        for (int k = 0; k < 2; k++)
          w[(ch*4 + r*2 + k)*16 +: 16] = 16'(ch*256 + (2*wr + r)*16 + 2*wc + k);
    return w;
  endfunction

  task automatic step(input bit s, input bit v, input logic [31:0] p);
    @(negedge clk);
    sof = s; valid_in = v; pix_in = p;
    @(posedge clk);
    #1;
  endtask

  task automatic frame_chk(input bit big, input bit gaps, input bit skip_first);
    int h, seen;
    logic vld, done, err;
    logic [127:0] win;
    bit ev;
    h = big ? 5 : 4;
    seen = 0;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < h; c++) begin
        if (skip_first && r == 0 && c == 0) continue;
        if (gaps) begin
          int n;
          n = $urandom_range(0, 3);
          for (int g = 0; g < n; g++) begin
            step(1'b0, 1'b0, 32'h0);
            chk("gap_valid", big ? wv5 : wv4, 0);
          end
        end
        step(r == 0 && c == 0, 1'b1, pixv(r, c, 0));
        vld  = big ? wv5 : wv4;
        done = big ? fd5 : fd4;
        err  = big ? fe5 : fe4;
        win  = big ? wo5 : wo4;
        ev = (r % 2 == 1) && (c % 2 == 1) && (r < 2*(h/2)) && (c < 2*(h/2));
        chk("win_valid", vld, ev);
        chk("frame_done", done, (r == h-1) && (c == h-1));
        chk("frame_err", err, 0);
        if (vld) seen++;
        if (ev) chk("win_data", win, exp_win(r/2, c/2));
      end
    end
    chk("win_count", seen, (h/2)*(h/2));
  endtask

  initial begin
    tbl[0]  = '{0,0,1,0,0,16'h0,16'h0};   tbl[1]  = '{0,1,0,0,0,16'h0,16'h0};
    tbl[2]  = '{0,2,0,0,0,16'h0,16'h0};   tbl[3]  = '{0,3,0,0,0,16'h0,16'h0};
    tbl[4]  = '{1,0,0,0,0,16'h0,16'h0};   tbl[5]  = '{1,1,0,1,0,16'h00,16'h111};
    tbl[6]  = '{1,2,0,0,0,16'h0,16'h0};   tbl[7]  = '{1,3,0,1,0,16'h02,16'h113};
    tbl[8]  = '{2,0,0,0,0,16'h0,16'h0};   tbl[9]  = '{2,1,0,0,0,16'h0,16'h0};
    tbl[10] = '{2,2,0,0,0,16'h0,16'h0};   tbl[11] = '{2,3,0,0,0,16'h0,16'h0};
    tbl[12] = '{3,0,0,0,0,16'h0,16'h0};   tbl[13] = '{3,1,0,1,0,16'h20,16'h131};
    tbl[14] = '{3,2,0,0,0,16'h0,16'h0};   tbl[15] = '{3,3,0,1,1,16'h22,16'h133};

    #2;
    chk("rst_valid", {wv4, wv5}, 0);
    chk("rst_done", {fd4, fd5}, 0);
    chk("rst_err", {fe4, fe5}, 0);
    chk("rst_win4", wo4, 0);
    chk("rst_win5", wo5, 0);
    @(negedge clk); rst = 1'b0;

    // Pixel without sof while idle is dropped and flagged, twice in a row.
    step(1'b0, 1'b1, pixv(0, 0, 0));
    chk("idle_err", fe4, 1); chk("idle_valid", wv4, 0);
    step(1'b0, 1'b0, 32'h0);
    chk("idle_err_clear", fe4, 0);
    step(1'b0, 1'b1, pixv(0, 1, 0));
    chk("idle_err_again", fe4, 1); chk("idle_valid_again", wv4, 0);
    step(1'b0, 1'b0, 32'h0);

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].s, 1'b1, pixv(tbl[i].r, tbl[i].c, 0));
      chk("tbl_valid", wv4, tbl[i].vld);
      chk("tbl_done", fd4, tbl[i].done);
      chk("tbl_err", fe4, 0);
      if (tbl[i].vld) begin
        chk("tbl_tl_ch0", wo4[15:0], tbl[i].tl0);
        chk("tbl_br_ch1", wo4[127:112], tbl[i].br1);
        chk("tbl_window", wo4, exp_win(tbl[i].r/2, tbl[i].c/2));
      end
    end
    chk("win3_ch1", wo4[127:64], {16'h133, 16'h132, 16'h123, 16'h122});
    step(1'b0, 1'b0, 32'h0);
    chk("hold_valid", wv4, 0);
    chk("hold_data", wo4, exp_win(1, 1));
    chk("hold_done", fd4, 0);

    frame_chk(1'b0, 1'b1, 1'b0);

    // Old frame carries an offset tag so any stale mixing is visible.
    for (int i = 0; i < 9; i++) step(i == 0, 1'b1, pixv(i/4, i%4, 'h800));
    step(1'b1, 1'b1, pixv(0, 0, 0));
    chk("midsof_err", fe4, 1);
    chk("midsof_valid", wv4, 0);
    frame_chk(1'b0, 1'b0, 1'b1);

    // Asynchronous reset mid-row 1, right after a window is emitted.
    for (int i = 0; i < 6; i++) step(i == 0, 1'b1, pixv(i/4, i%4, 0));
    chk("pre_rst_valid", wv4, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", wv4, 0);
    chk("async_rst_win", wo4, 0);
    chk("async_rst_flags", {fd4, fe4}, 0);
    @(negedge clk); rst = 1'b0;
    frame_chk(1'b0, 1'b0, 1'b0);

    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    frame_chk(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0);
    chk("odd_done_clear", fd5, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pool_window_former.md
Name: pool_window_former

Overview:
- Streaming 2x2 / stride-2 window generator that drives the max-pooling layer's per-channel 2x2 window inputs.
- Accepts one feature-map pixel position per cycle, raster order, all channels in parallel.
- Buffers the top row of each window pair and emits one complete 2x2 window per channel, with a valid strobe, when the bottom-right pixel arrives.
- Sits between the convolution/activation output stream and the pooling top.

Parameters:
- DATA_W, 32: bits per channel sample.
- CH, 64: channels presented in parallel.
- IMG_W, 8: pixels per input row (>=2).
- IMG_H, 8: rows per input frame (>=2).

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- sof  input  1  start of frame; qualified by valid_in; marks pixel (0,0).
- valid_in  input  1  pix_in carries a pixel this cycle.
- pix_in  input  CH*DATA_W  channel c at [c*DATA_W +: DATA_W].
- win_valid  output  1  win_out holds a complete window this cycle.
- win_out  output  CH*4*DATA_W  channel c, window row r (0=top), col k (0=left) at [(c*4+r*2+k)*DATA_W +: DATA_W].
- frame_done  output  1  one-cycle pulse with the frame's last accepted pixel.
- frame_err  output  1  one-cycle pulse on protocol violation.

Behaviour:
- Reset (async, any time, including mid-frame):
  - win_valid, frame_done and frame_err go to 0; win_out goes to 0.
  - row/col counters clear; state goes to IDLE.
  - Line-buffer contents are don't-care.
- States: IDLE, TOP, BOTTOM, TAIL.
- IDLE:
  - valid_in&sof accepts the pixel as (0,0); next state TOP.
  - valid_in without sof: pixel dropped, frame_err pulses the next cycle.
- Counters:
  - col counts 0..IMG_W-1 per accepted pixel, then wraps to 0 and row increments.
  - No activity when valid_in=0; gaps of any length are allowed.
- TOP (even row):
  - At even col, store the pixel in the left half of line-buffer entry col/2.
  - At odd col, store it in the right half.
  - At end of row, go to BOTTOM.
- BOTTOM (odd row):
  - At even col, hold the pixel in a left register.
  - At odd col, form the window: top from line-buffer entry col/2, bottom-left from the held register, bottom-right from pix_in.
  - win_out and win_valid are registered and appear exactly 1 cycle after that valid_in.
  - At end of row, go to TOP; go to TAIL instead if the next row is IMG_H-1 and IMG_H is odd.
- TAIL: pixels are consumed but produce no windows.
- Odd dimensions (floor pooling):
  - Odd IMG_W: the last column never contributes to a window.
  - Odd IMG_H: the last row never contributes to a window.
- Windows per frame = (IMG_W/2)*(IMG_H/2), emitted in raster order of window position.
- Frame end:
  - On acceptance of pixel (IMG_H-1, IMG_W-1), frame_done pulses the next cycle, aligned with the final win_valid when one exists.
  - State returns to IDLE.
- sof mid-frame (valid_in&sof outside IDLE):
  - Current frame is aborted and frame_err pulses.
  - The pixel is taken as (0,0) of a new frame; no window is formed from stale buffer data.
- win_out holds its last value while win_valid=0.
- No backpressure: the downstream pooling top always accepts.
- Throughput: one pixel per cycle sustained.
- Data is passed through unmodified; no arithmetic on samples.

Decomposition:
- Shared package pool_pkg:
  - DATA_W and CH defaults.
  - State enum typedef.
  - Window-slot index function (c,r,k) -> bit offset, shared with the pooling top and benches.
- One sub-module, pool_line_buf:
  - Parameterised array of IMG_W/2 entries, each 2*CH*DATA_W.
  - Independent left/right half write enables and one combinational read port.

Test Plan (CH=2, IMG_W=4, IMG_H=4, pixel value = ch*256 + row*16 + col):
- Contiguous frame with sof on the first pixel.
  - 4 windows, each win_valid 1 cycle after pixels (1,1), (1,3), (3,1), (3,3).
  - Window 0, ch0: [0][0]=0x00, [0][1]=0x01, [1][0]=0x10, [1][1]=0x11.
  - Window 3, ch1: 0x122, 0x123, 0x132, 0x133.
  - frame_done coincident with the 4th win_valid.
- Same frame with random 0-3 cycle valid_in gaps: identical window values and order; win_valid still exactly 1 cycle after each completing pixel.
- IMG_W=5, IMG_H=5 build:
  - 4 windows only; column 4 and row 4 never appear in any window.
  - frame_done 1 cycle after pixel (4,4), with win_valid=0 on that cycle.
- Mid-frame sof at pixel (2,1):
  - frame_err pulses.
  - The following 16 pixels yield the 4 correct windows of the new frame.
  - No window is emitted mixing old-frame data.
- valid_in without sof while IDLE: frame_err pulse, no window, state stays IDLE.
- rst asserted asynchronously mid-row 1:
  - All outputs 0 immediately.
  - A subsequent full frame with sof produces correct windows.
